// File: rtl/aud_pkg.sv
// Shared definitions for the audio record/playback controllers: default
// widths and the controller state encoding shown on the front-panel display.
package aud_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;
  localparam int STATE_W    = 3;

  // The encoding is visible on o_state, so the values are pinned explicitly.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_REC   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_FLUSH = 3'd4,
    ST_DONE  = 3'd5
  } rec_state_e;

endpackage

// File: rtl/aud_rec_ctrl_if.sv
// SRAM arbiter write channel: a valid/ready handshake carrying a word
// address and one sample.
interface aud_rec_ctrl_if
  import aud_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/lrc_edge_det.sv
// LRC edge detector: registers the previous LRC level and produces
// single-cycle rise/fall pulses. Shared with the player controller.
module lrc_edge_det (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_lrc,
  output logic o_rise,
  output logic o_fall
);

  logic lrc_d;

  // Keep last cycle's LRC level so transitions are visible this cycle.
  always_ff @(posedge i_clk) begin
    // NOTE: flops are written with <= so every register samples pre-edge
    // values; a blocking = here would make simulation order-dependent.
    if (i_rst) lrc_d <= 1'b0;
    else       lrc_d <= i_lrc;
  end

  assign o_rise = i_lrc & ~lrc_d;
  assign o_fall = ~i_lrc & lrc_d;

endmodule

// File: rtl/aud_rec_ctrl.sv
// Recording controller: aligns to left frames, gates the deserializer,
// and commits each completed left sample to the SRAM write channel with a
// linear, non-wrapping address. Tracks take length, full and overrun.
module aud_rec_ctrl
  import aud_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic               i_stop,
  input  logic               i_lrc,
  input  logic [DATA_W-1:0]  i_sample,
  output logic               o_rec_en,
  aud_rec_ctrl_if.master     wr,
  output logic [ADDR_W:0]    o_len,
  output logic [STATE_W-1:0] o_state,
  output logic               o_full,
  output logic               o_overrun
);

  rec_state_e state_q, state_d;

  logic rise, fall;
  logic accept, at_max, pending_after;
  logic capture, drop, clear;

  lrc_edge_det u_lrc_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_lrc  (i_lrc),
    .o_rise (rise),
    .o_fall (fall)
  );

  assign accept        = wr.valid & wr.ready;
  assign at_max        = (wr.addr == MAX_ADDR);
  // A write still outstanding after this cycle's handshake.
  assign pending_after = wr.valid & ~wr.ready;

  // A left sample is complete at LRC rise; it is only taken while recording.
  // If the previous write is still waiting, the new sample is lost.
  assign capture = (state_q == ST_REC) & rise & ~i_stop & ~wr.valid;
  assign drop    = (state_q == ST_REC) & rise & ~i_stop &  wr.valid;

  // A fresh take starts from IDLE/DONE; a resume from PAUSE keeps its address.
  assign clear = ((state_q == ST_IDLE) | (state_q == ST_DONE)) & (state_d == ST_ARM);

  // The deserializer runs from the aligning fall onward, so it starts on a
  // clean frame boundary rather than mid-sample.
  assign o_rec_en = (state_q == ST_REC) | ((state_q == ST_ARM) & (state_d == ST_REC));
  assign o_state  = state_q;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; stop outranks start, which outranks pause.
  always_comb begin
    // NOTE: defaulting state_d before the case guarantees every path assigns
    // it, so no latch is inferred for the unlisted branches.
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start && !i_stop) state_d = ST_ARM;
      end
      ST_ARM, ST_REC, ST_PAUSE: begin
        if (i_stop)                                state_d = pending_after ? ST_FLUSH : ST_IDLE;
        else if (accept && at_max)                 state_d = ST_DONE;
        else if (state_q == ST_ARM && fall)        state_d = ST_REC;
        else if (state_q == ST_REC && i_pause)     state_d = ST_PAUSE;
        else if (state_q == ST_PAUSE && i_start)   state_d = ST_ARM;
      end
      ST_FLUSH: begin
        if (accept) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write channel, take length and sticky status flags.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr.valid  <= 1'b0;
      wr.addr   <= '0;
      wr.data   <= '0;
      o_len     <= '0;
      o_full    <= 1'b0;
      o_overrun <= 1'b0;
    end else if (clear) begin
      wr.addr   <= '0;
      o_len     <= '0;
      o_full    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      if (accept) begin
        wr.valid <= 1'b0;
        o_len    <= o_len + 1'b1;
        // The last word stays addressed; recording stops instead of wrapping.
        if (at_max) o_full  <= 1'b1;
        else        wr.addr <= wr.addr + 1'b1;
      end
      if (capture) begin
        wr.valid <= 1'b1;
        wr.data  <= i_sample;
      end
      if (drop) o_overrun <= 1'b1;
    end
  end

endmodule
